// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch slice: FSM state encoding, default boot PC
// and the instruction-queue entry layout.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/fetch_unit_inst_queue.sv
// Circular instruction queue: wrapping head/tail pointers plus an explicit
// occupancy count; flush empties it and wins over enqueue/dequeue.
module inst_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq,
    input  logic [IQ_ENTRY_W-1:0]   enq_data,
    input  logic                    deq,
    input  logic                    flush,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic [IQ_ENTRY_W-1:0]   head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [IQ_ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  do_enq;
    logic                  do_deq;

    always_comb begin
        do_enq = enq && !flush && (count != FULL);
        do_deq = deq && !flush && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) tail <= tail + PTR_W'(1);
            if (do_deq) head <= head + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[tail] <= enq_data;
    end

    always_comb begin
        valid     = (count != '0);
        head_data = mem[head];
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher feeding inst_queue.
// Optional feature: define FETCH_STALL_CNT_EN to add the fetch_stall_cycles counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_mem_read,
    output logic [31:0] fetch_mem_address,
    input  logic [31:0] fetch_mem_rdata,
    input  logic        fetch_mem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        iq_deq,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0] fetch_stall_cycles,
`endif
    output logic [31:0] iq_pc
);

    localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(IQ_DEPTH);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic [CNT_W-1:0] iq_count;
    logic             enq;
    iq_entry_t        enq_entry;
    iq_entry_t        head_entry;
    logic [1:0]       unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A redirect never cancels an in-flight read: without resp it parks in DROP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!redirect && (iq_count < FULL)) state_next = REQ;
            REQ: begin
                if (redirect)            state_next = fetch_mem_resp ? IDLE : DROP;
                else if (fetch_mem_resp) state_next = IDLE;
            end
            DROP: if (fetch_mem_resp) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fetch_mem_read    = (state == REQ) || (state == DROP);
        fetch_mem_address = req_addr;
        enq               = (state == REQ) && fetch_mem_resp && !redirect;
        enq_entry.inst    = fetch_mem_rdata;
        enq_entry.pc      = req_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect) pc <= {redirect_pc[31:2], 2'b00};
            else if (enq) pc <= pc + 32'd4;
            if ((state == IDLE) && (state_next == REQ)) req_addr <= pc;
        end
    end

    inst_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .enq_data  (enq_entry),
        .deq       (iq_deq),
        .flush     (redirect),
        .valid     (iq_valid),
        .count     (iq_count),
        .head_data (head_entry)
    );

    always_comb begin
        iq_inst = head_entry.inst;
        iq_pc   = head_entry.pc;
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            fetch_stall_cycles <= '0;
        else if (fetch_mem_read && !fetch_mem_resp && (fetch_stall_cycles != '1))
            fetch_stall_cycles <= fetch_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: background memory responder plus table-driven
// queue drain checks and hand-written redirect/reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_mem_read;
    logic [31:0] fetch_mem_address;
    logic [31:0] fetch_mem_rdata;
    logic        fetch_mem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        iq_deq;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] fetch_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    int lat      = 2;
    bit free_run = 1'b1;
    int grant    = 0;
    int resp_seen = 0;
    logic [31:0] req_log [$];

    typedef struct {
        logic        deq;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs [10];

    fetch_unit #(
        .IQ_DEPTH (8),
        .RESET_PC (32'h0000_0060)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_mem_read    (fetch_mem_read),
        .fetch_mem_address (fetch_mem_address),
        .fetch_mem_rdata   (fetch_mem_rdata),
        .fetch_mem_resp    (fetch_mem_resp),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .iq_deq            (iq_deq),
        .iq_valid          (iq_valid),
        .iq_inst           (iq_inst),
`ifdef FETCH_STALL_CNT_EN
        .fetch_stall_cycles(fetch_stall_cycles),
`endif
        .iq_pc             (iq_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_new_req(input string name, input logic [31:0] exp);
        int sz;
        bit got;
        sz  = req_log.size();
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_log.size() > sz) begin
                got = 1'b1;
                break;
            end
        end
        if (got) check(name, req_log[req_log.size()-1], exp);
        else     fail_timeout(name);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check("vec_valid", 32'(iq_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check("vec_pc", iq_pc, vecs[i].exp_pc);
                check("vec_inst", iq_inst, data_of(vecs[i].exp_pc));
            end
            iq_deq = vecs[i].deq;
            tick();
            iq_deq = 1'b0;
        end
    endtask

    // Memory side: responds lat cycles after a read appears, gated by free_run/grant.
    initial begin
        int          wcnt;
        logic        prev_read;
        logic [31:0] prev_addr;
        wcnt            = 0;
        prev_read       = 1'b0;
        prev_addr       = '0;
        fetch_mem_resp  = 1'b0;
        fetch_mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                fetch_mem_resp = 1'b0;
                wcnt           = 0;
                prev_read      = 1'b0;
            end else begin
                if (fetch_mem_read && !prev_read)
                    req_log.push_back(fetch_mem_address);
                else if (fetch_mem_read && prev_read)
                    check("addr_stable", fetch_mem_address, prev_addr);
                if (fetch_mem_resp) begin
                    fetch_mem_resp = 1'b0;
                    wcnt           = 0;
                end else if (fetch_mem_read) begin
                    if (wcnt >= lat && (free_run || grant > 0)) begin
                        fetch_mem_resp  = 1'b1;
                        fetch_mem_rdata = data_of(fetch_mem_address);
                        if (!free_run) grant--;
                        resp_seen++;
                    end else if (wcnt < lat) begin
                        wcnt++;
                    end
                end
                prev_read = fetch_mem_read;
                prev_addr = fetch_mem_address;
            end
        end
    end

    initial begin
        bit got;
        int base;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        iq_deq      = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 32'h60};
        vecs[1] = '{1'b1, 1'b1, 32'h64};
        vecs[2] = '{1'b1, 1'b1, 32'h68};
        vecs[3] = '{1'b1, 1'b1, 32'h6C};
        vecs[4] = '{1'b1, 1'b1, 32'h70};
        vecs[5] = '{1'b1, 1'b1, 32'h78};
        vecs[6] = '{1'b1, 1'b1, 32'h7C};
        vecs[7] = '{1'b1, 1'b1, 32'h80};
        vecs[8] = '{1'b1, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 32'h0};

        repeat (3) tick();
        check("rst_read", 32'(fetch_mem_read), 32'd0);
        check("rst_valid", 32'(iq_valid), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall", fetch_stall_cycles, 32'd0);
`endif

        // Fill with no dequeue: exactly IQ_DEPTH requests, then idle.
        rst = 1'b0;
        repeat (50) tick();
        check("fill_req_count", 32'(req_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check("fill_addr", req_log[i], 32'h60 + 32'(4 * i));
        check("full_read_idle", 32'(fetch_mem_read), 32'd0);

        free_run = 1'b0;
        run_vecs(0, 4);
        repeat (3) tick();
        check("refill_req_count", 32'(req_log.size()), 32'd9);
        check("refill_addr", req_log[req_log.size()-1], 32'h80);

        // Enqueue and dequeue on the same edge with count=3; tail wraps to index 0.
        check("pre_wrap_head", iq_pc, 32'h74);
        grant = 1;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_mem_resp) begin
                iq_deq = 1'b1;
                tick();
                iq_deq = 1'b0;
                got    = 1'b1;
                break;
            end
        end
        if (!got) fail_timeout("wrap_resp");
        run_vecs(5, 9);

        // Redirect while waiting: request held, response dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h70;
        tick();
        redirect = 1'b0;
        check("drop_read", 32'(fetch_mem_read), 32'd1);
        check("drop_addr", fetch_mem_address, 32'h84);
        check("drop_valid", 32'(iq_valid), 32'd0);
        grant = 1;
        wait_new_req("restart_addr", 32'h70);
        check("restart_valid", 32'(iq_valid), 32'd0);

        redirect    = 1'b1;
        redirect_pc = 32'h1003;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_read", 32'(fetch_mem_read), 32'd1);
            check("hold_addr", fetch_mem_address, 32'h70);
            check("hold_valid", 32'(iq_valid), 32'd0);
            tick();
        end
        grant = 1;
        wait_new_req("redir_addr", 32'h1000);
        check("redir_valid", 32'(iq_valid), 32'd0);

        // Redirect coincident with resp: data discarded, no DROP phase.
        grant = 1;
        got   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_mem_resp) begin
                redirect    = 1'b1;
                redirect_pc = 32'h2000;
                tick();
                redirect = 1'b0;
                got      = 1'b1;
                break;
            end
        end
        if (!got) fail_timeout("coinc_resp");
        check("coinc_valid", 32'(iq_valid), 32'd0);
        wait_new_req("coinc_addr", 32'h2000);

        // Reset in the middle of an outstanding request.
        rst = 1'b1;
        tick();
        check("rst_abandon_read", 32'(fetch_mem_read), 32'd0);
        check("rst_abandon_valid", 32'(iq_valid), 32'd0);

        // Ten fetches with four wait cycles each, decode popping continuously.
        lat      = 4;
        grant    = 10;
        iq_deq   = 1'b1;
        base     = resp_seen;
        rst      = 1'b0;
        wait_new_req("post_rst_addr", 32'h60);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (resp_seen == base + 10 && fetch_mem_resp) begin
                tick();
                check("tenth_valid", 32'(iq_valid), 32'd1);
                check("tenth_pc", iq_pc, 32'h84);
                check("tenth_inst", iq_inst, data_of(32'h84));
`ifdef FETCH_STALL_CNT_EN
                check("stall_cycles", fetch_stall_cycles, 32'd40);
`endif
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_timeout("stall_run");
        iq_deq = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter IQ_DEPTH, default 8, instruction-queue entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0060, first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fetch_mem_read  output  1  instruction read request to the memory arbiter fetch port.
REQ-006 fetch_mem_address  output  32  word-aligned fetch address.
REQ-007 fetch_mem_rdata  input  32  returned instruction; valid only while fetch_mem_resp=1.
REQ-008 fetch_mem_resp  input  1  one-cycle completion pulse from the arbiter.
REQ-009 redirect  input  1  flush and restart fetch, driven on branch mispredict or exception.
REQ-010 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
REQ-011 iq_deq  input  1  decode pops the head entry this cycle.
REQ-012 iq_valid  output  1  queue non-empty.
REQ-013 iq_inst  output  32  head instruction.
REQ-014 iq_pc  output  32  head instruction PC.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and DROP.
REQ-016 IDLE: when redirect=0 and count<IQ_DEPTH, latch req_addr<=pc and enter REQ next cycle; otherwise remain in IDLE.
REQ-017 REQ and DROP: fetch_mem_read=1 and fetch_mem_address=req_addr, both held stable until fetch_mem_resp.
REQ-018 IDLE: fetch_mem_read=0 and fetch_mem_address=req_addr.
REQ-019 REQ, resp=1, redirect=0: enqueue {fetch_mem_rdata, req_addr}, pc<=pc+4 (wraps mod 2^32), next state IDLE.
  - Consequence: read drops for at least one cycle between requests, so the arbiter can return to its poll state.
REQ-020 REQ, resp=0, redirect=1: flush queue, pc<=redirect_pc, next state DROP.
  - The outstanding request is never withdrawn.
REQ-021 REQ, resp=1, redirect=1 in the same cycle: discard the response, flush, pc<=redirect_pc, next state IDLE.
REQ-022 DROP, on resp: discard the data and enter IDLE. A further redirect while in DROP updates pc and stays in DROP.
REQ-023 Queue: circular buffer with log2(IQ_DEPTH)-bit head/tail pointers that wrap, plus an explicit count.
  - Enqueue and dequeue in the same cycle leave count unchanged.
REQ-024 iq_deq while empty SHALL be ignored.
REQ-025 redirect takes priority over iq_deq and enqueue in the same cycle.
  - After a redirect the queue is empty: count=0, iq_valid=0 next cycle.
REQ-026 Only one request is outstanding at a time; issue is gated by count<IQ_DEPTH, so an enqueue never finds the queue full.
REQ-027 iq_inst and iq_pc are driven combinationally from the head entry; their values are don't-care when iq_valid=0.
REQ-028 Minimum fetch latency: the response is enqueued on the resp cycle and is visible at the head (iq_valid=1) the next cycle.

Reset
REQ-029 On rst: state=IDLE, pc=RESET_PC, req_addr=RESET_PC, head=tail=count=0.
  - Outputs: fetch_mem_read=0, iq_valid=0.
REQ-030 rst asserted mid-request SHALL abandon the request immediately; the memory side is reset by the same rst.

Configuration
REQ-031 Macro FETCH_STALL_CNT_EN.
  - Defined: adds output fetch_stall_cycles (32 bits), cleared by rst, incrementing each cycle in REQ or DROP with resp=0; saturates at 32'hFFFF_FFFF.
  - Undefined: the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, RESET_PC default value and the queue entry struct {inst[31:0], pc[31:0]}.
REQ-033 The queue SHALL be a sub-module, inst_queue (parameter DEPTH; ports enq, enq_data, deq, flush, valid, count, head_data); the FSM and pc logic stay in fetch_unit.

Verification
REQ-034 Reset, memory with 2-cycle resp -> first request has address 0x60; queue fills with PCs 0x60, 0x64, ... each paired with its returned data.
REQ-035 IQ_DEPTH=8, iq_deq=0 -> exactly 8 requests issued, then fetch_mem_read stays 0; one iq_deq -> one new request, at address 0x80.
REQ-036 redirect to 0x1003 while in REQ at address 0x70 -> read held at 0x70 until resp, data dropped; next request is 0x1000 and queue empty.
REQ-037 redirect coincident with resp -> response not enqueued, iq_valid=0 next cycle, next request at redirect_pc.
REQ-038 Simultaneous iq_deq and enqueue with count=3 -> count stays 3, head advances, pointers wrap correctly past index 7.
REQ-039 With FETCH_STALL_CNT_EN, 10 requests of 4 wait cycles each -> fetch_stall_cycles=40.
